// File: rtl/video_mem_arbiter_if.sv
// rtl/video_mem_arbiter_if.sv - framebuffer, CPU and memory-port signals of the video memory arbiter
interface video_mem_arbiter_if;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_ack;
  logic [7:0]  cpu_dout;
  logic        mem_req;
  logic        mem_we;
  logic        mem_burst;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_q;
  logic [31:0] vdata;
  logic [31:0] vdata2;
  logic [31:0] vdata3;
  logic [31:0] vdata4;
  logic        vid_done;
  logic        video_slice;
  logic        vid_overrun;
  logic        mem_err;

  modport master (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
    input  mem_ack, mem_rvalid, mem_q,
    output cpu_ack, cpu_dout, mem_req, mem_we, mem_burst, mem_addr, mem_din,
    output vdata, vdata2, vdata3, vdata4, vid_done, video_slice, vid_overrun, mem_err
  );

  modport slave (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din,
    output mem_ack, mem_rvalid, mem_q,
    input  cpu_ack, cpu_dout, mem_req, mem_we, mem_burst, mem_addr, mem_din,
    input  vdata, vdata2, vdata3, vdata4, vid_done, video_slice, vid_overrun, mem_err
  );
endinterface

// File: rtl/video_mem_arbiter.sv
// rtl/video_mem_arbiter.sv - shares the video memory port between framebuffer bursts and CPU byte accesses
// Optional transaction watchdog enabled by defining VIDARB_WATCHDOG_EN.
module video_mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input logic                 clk24,
  input logic                 reset,
  video_mem_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, V_CMD, V_DATA, C_CMD, C_DATA} state_t;

  state_t      state, state_n;
  logic        vid_pend, vid_pend_n;
  logic [15:0] vid_addr_q, vid_addr_q_n;
  logic [1:0]  idx, idx_n;
  logic [31:0] sh0, sh1, sh2, sh0_n, sh1_n, sh2_n;
  logic        mem_req_q, mem_req_n;
  logic        mem_we_q, mem_we_n;
  logic        mem_burst_q, mem_burst_n;
  logic [15:0] mem_addr_q, mem_addr_n;
  logic [7:0]  mem_din_q, mem_din_n;
  logic        cpu_ack_q, cpu_ack_n;
  logic [7:0]  cpu_dout_q, cpu_dout_n;
  logic [31:0] vd0_q, vd1_q, vd2_q, vd3_q;
  logic [31:0] vd0_n, vd1_n, vd2_n, vd3_n;
  logic        vid_done_q, vid_done_n;
  logic        video_slice_q, video_slice_n;
  logic        vid_overrun_q, vid_overrun_n;
  logic        wd_expired;

  if (TIMEOUT < 2) begin : g_timeout_check
    $error("TIMEOUT must be at least 2");
  end

`ifdef VIDARB_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [WD_W-1:0] wd_cnt;
  logic            mem_err_q;

  // Any memory-side activity counts as progress, even on the expiry cycle.
  assign wd_expired = (state != IDLE) && !(bus.mem_ack || bus.mem_rvalid) &&
                      (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk24) begin
    if (reset) begin
      wd_cnt    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      if (state_n == IDLE || state_n != state || bus.mem_ack || bus.mem_rvalid)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 1'b1;
      if (wd_expired)
        mem_err_q <= 1'b1;
    end
  end

  assign bus.mem_err = mem_err_q;
`else
  assign wd_expired  = 1'b0;
  assign bus.mem_err = 1'b0;
`endif

  always_ff @(posedge clk24) begin
    if (reset) begin
      state         <= IDLE;
      vid_pend      <= 1'b0;
      vid_addr_q    <= '0;
      idx           <= '0;
      sh0           <= '0;
      sh1           <= '0;
      sh2           <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_burst_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      cpu_ack_q     <= 1'b0;
      cpu_dout_q    <= '0;
      vd0_q         <= '0;
      vd1_q         <= '0;
      vd2_q         <= '0;
      vd3_q         <= '0;
      vid_done_q    <= 1'b0;
      video_slice_q <= 1'b0;
      vid_overrun_q <= 1'b0;
    end else begin
      state         <= state_n;
      vid_pend      <= vid_pend_n;
      vid_addr_q    <= vid_addr_q_n;
      idx           <= idx_n;
      sh0           <= sh0_n;
      sh1           <= sh1_n;
      sh2           <= sh2_n;
      mem_req_q     <= mem_req_n;
      mem_we_q      <= mem_we_n;
      mem_burst_q   <= mem_burst_n;
      mem_addr_q    <= mem_addr_n;
      mem_din_q     <= mem_din_n;
      cpu_ack_q     <= cpu_ack_n;
      cpu_dout_q    <= cpu_dout_n;
      vd0_q         <= vd0_n;
      vd1_q         <= vd1_n;
      vd2_q         <= vd2_n;
      vd3_q         <= vd3_n;
      vid_done_q    <= vid_done_n;
      video_slice_q <= video_slice_n;
      vid_overrun_q <= vid_overrun_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (vid_pend || bus.vid_req)
          state_n = V_CMD;
        else if (bus.cpu_req && !cpu_ack_q)
          state_n = C_CMD;
      end
      V_CMD:   if (bus.mem_ack) state_n = V_DATA;
      V_DATA:  if (bus.mem_rvalid && idx == 2'd3) state_n = IDLE;
      C_CMD:   if (bus.mem_ack) state_n = mem_we_q ? IDLE : C_DATA;
      C_DATA:  if (bus.mem_rvalid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (wd_expired)
      state_n = IDLE;
  end

  always_comb begin
    vid_pend_n    = vid_pend | bus.vid_req;
    vid_addr_q_n  = bus.vid_req ? bus.vid_addr : vid_addr_q;
    vid_overrun_n = vid_overrun_q | (bus.vid_req & vid_pend);
    idx_n         = idx;
    sh0_n         = sh0;
    sh1_n         = sh1;
    sh2_n         = sh2;
    mem_req_n     = mem_req_q;
    mem_we_n      = mem_we_q;
    mem_burst_n   = mem_burst_q;
    mem_addr_n    = mem_addr_q;
    mem_din_n     = mem_din_q;
    cpu_ack_n     = 1'b0;
    cpu_dout_n    = cpu_dout_q;
    vd0_n         = vd0_q;
    vd1_n         = vd1_q;
    vd2_n         = vd2_q;
    vd3_n         = vd3_q;
    vid_done_n    = 1'b0;

    case (state)
      IDLE: begin
        // The burst launched here serves the newest request; older ones were already flagged as overrun.
        if (vid_pend || bus.vid_req) begin
          vid_pend_n  = 1'b0;
          mem_req_n   = 1'b1;
          mem_burst_n = 1'b1;
          mem_we_n    = 1'b0;
          mem_addr_n  = vid_addr_q_n;
        end else if (bus.cpu_req && !cpu_ack_q) begin
          mem_req_n   = 1'b1;
          mem_burst_n = 1'b0;
          mem_we_n    = bus.cpu_we;
          mem_addr_n  = bus.cpu_addr;
          mem_din_n   = bus.cpu_din;
        end
      end
      V_CMD: begin
        if (bus.mem_ack) begin
          mem_req_n = 1'b0;
          idx_n     = 2'd0;
        end
      end
      V_DATA: begin
        if (bus.mem_rvalid) begin
          idx_n = idx + 2'd1;
          case (idx)
            2'd0: sh0_n = bus.mem_q;
            2'd1: sh1_n = bus.mem_q;
            2'd2: sh2_n = bus.mem_q;
            default: begin
              vd0_n      = sh0;
              vd1_n      = sh1;
              vd2_n      = sh2;
              vd3_n      = bus.mem_q;
              vid_done_n = 1'b1;
            end
          endcase
        end
      end
      C_CMD: begin
        if (bus.mem_ack) begin
          mem_req_n = 1'b0;
          cpu_ack_n = mem_we_q;
        end
      end
      C_DATA: begin
        if (bus.mem_rvalid) begin
          cpu_ack_n = 1'b1;
          case (bus.cpu_addr[1:0])
            2'd0:    cpu_dout_n = bus.mem_q[7:0];
            2'd1:    cpu_dout_n = bus.mem_q[15:8];
            2'd2:    cpu_dout_n = bus.mem_q[23:16];
            default: cpu_dout_n = bus.mem_q[31:24];
          endcase
        end
      end
      default: ;
    endcase

    // Abort: a stalled CPU access still completes so the CPU never hangs.
    if (wd_expired) begin
      mem_req_n = 1'b0;
      if (state == C_CMD || state == C_DATA) begin
        cpu_ack_n  = 1'b1;
        cpu_dout_n = 8'hFF;
      end
    end

    video_slice_n = (state_n == V_CMD) || (state_n == V_DATA);
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_burst   = mem_burst_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_din     = mem_din_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.cpu_dout    = cpu_dout_q;
  assign bus.vdata       = vd0_q;
  assign bus.vdata2      = vd1_q;
  assign bus.vdata3      = vd2_q;
  assign bus.vdata4      = vd3_q;
  assign bus.vid_done    = vid_done_q;
  assign bus.video_slice = video_slice_q;
  assign bus.vid_overrun = vid_overrun_q;

endmodule

// File: tb/tb_video_mem_arbiter.sv
// tb/tb_video_mem_arbiter.sv - directed and randomized self-checking bench for video_mem_arbiter
module tb_video_mem_arbiter;
  logic clk24 = 1'b0;
  logic reset = 1'b1;
  always #5 clk24 = ~clk24;

  video_mem_arbiter_if bus();

  video_mem_arbiter #(.TIMEOUT(64)) dut (
    .clk24(clk24),
    .reset(reset),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int n_done = 0;
  int n_ack = 0;
  logic [31:0] exp_v [4];
  logic exp_overrun = 1'b0;
  logic exp_err = 1'b0;

  // Pulse counters, sampled just after each rising edge.
  always @(posedge clk24) begin
    #1;
    if (bus.vid_done === 1'b1) n_done++;
    if (bus.cpu_ack === 1'b1) n_ack++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk24);
  endtask

  task automatic wait_req(input string tag);
    int t = 0;
    while (bus.mem_req !== 1'b1 && t < 100) begin
      cyc();
      t++;
    end
    chk({tag, "_req_seen"}, bus.mem_req, 1);
  endtask

  task automatic serve_cmd(input string tag, input bit burst, input bit we,
                           input logic [15:0] addr, input logic [7:0] din, input int dly);
    wait_req(tag);
    chk({tag, "_burst"}, bus.mem_burst, burst);
    chk({tag, "_we"}, bus.mem_we, we);
    chk({tag, "_addr"}, bus.mem_addr, addr);
    if (we) chk({tag, "_din"}, bus.mem_din, din);
    chk({tag, "_slice"}, bus.video_slice, burst);
    cyc(dly);
    chk({tag, "_held"}, bus.mem_req, 1);
    bus.mem_ack = 1'b1;
    cyc();
    bus.mem_ack = 1'b0;
    chk({tag, "_req_drop"}, bus.mem_req, 0);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    cyc(gap);
    bus.mem_rvalid = 1'b1;
    bus.mem_q = w;
    cyc();
    bus.mem_rvalid = 1'b0;
    bus.mem_q = $urandom;
  endtask

  task automatic run_burst_data(input logic [31:0] w [4], input int maxgap);
    int d0 = n_done;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("vid_done_early", bus.vid_done, 0);
      send_word(w[i], $urandom_range(0, maxgap));
    end
    chk("vid_done", bus.vid_done, 1);
    chk("vdata", bus.vdata, w[0]);
    chk("vdata2", bus.vdata2, w[1]);
    chk("vdata3", bus.vdata3, w[2]);
    chk("vdata4", bus.vdata4, w[3]);
    chk("slice_after_burst", bus.video_slice, 0);
    chk("one_vid_done", n_done, d0 + 1);
    exp_v = w;
  endtask

  task automatic video_burst(input logic [15:0] addr, input int dly, input int maxgap);
    logic [31:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    bus.vid_req = 1'b1;
    bus.vid_addr = addr;
    cyc();
    bus.vid_req = 1'b0;
    bus.vid_addr = 16'($urandom);
    chk("vid_req_latency", bus.mem_req, 1);
    serve_cmd("vburst", 1'b1, 1'b0, addr, 8'h00, dly);
    run_burst_data(w, maxgap);
  endtask

  task automatic cpu_access(input bit we, input logic [15:0] addr, input logic [7:0] din,
                            input logic [31:0] q, input int dly, input bit hold);
    int a0 = n_ack;
    logic [7:0] exp_b;
    bus.cpu_req = 1'b1;
    bus.cpu_we = we;
    bus.cpu_addr = addr;
    bus.cpu_din = din;
    serve_cmd(we ? "cpu_wr" : "cpu_rd", 1'b0, we, addr, din, dly);
    if (!we) begin
      chk("cpu_rd_early_ack", bus.cpu_ack, 0);
      send_word(q, $urandom_range(0, 2));
      exp_b = 8'(q >> (8 * addr[1:0]));
      chk("cpu_dout", bus.cpu_dout, exp_b);
    end
    chk("cpu_ack", bus.cpu_ack, 1);
    if (!hold) bus.cpu_req = 1'b0;
    cyc();
    bus.cpu_req = 1'b0;
    chk("cpu_no_reissue", bus.mem_req, 0);
    cyc();
    chk("cpu_no_reissue2", bus.mem_req, 0);
    chk("cpu_one_ack", n_ack, a0 + 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_mem_req"}, bus.mem_req, 0);
    chk({tag, "_mem_burst"}, bus.mem_burst, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_slice"}, bus.video_slice, 0);
    chk({tag, "_vid_done"}, bus.vid_done, 0);
    chk({tag, "_cpu_ack"}, bus.cpu_ack, 0);
    chk({tag, "_cpu_dout"}, bus.cpu_dout, 0);
    chk({tag, "_vdata"}, bus.vdata | bus.vdata2 | bus.vdata3 | bus.vdata4, 0);
    chk({tag, "_overrun"}, bus.vid_overrun, 0);
    chk({tag, "_mem_err"}, bus.mem_err, 0);
  endtask

  initial begin
    logic [31:0] w [4];
    int d0;
    int cnt;
    bus.vid_req = 0; bus.vid_addr = 0; bus.cpu_req = 0; bus.cpu_we = 0;
    bus.cpu_addr = 0; bus.cpu_din = 0; bus.mem_ack = 0; bus.mem_rvalid = 0; bus.mem_q = 0;
    for (int i = 0; i < 4; i++) exp_v[i] = 32'h0;
    reset = 1'b1;
    cyc(3);
    check_idle_outputs("reset");
    reset = 1'b0;
    cyc(2);

    // Video burst from the test plan.
    w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333; w[3] = 32'h44444444;
    bus.vid_req = 1'b1;
    bus.vid_addr = 16'h8000;
    cyc();
    bus.vid_req = 1'b0;
    chk("plan_req_latency", bus.mem_req, 1);
    serve_cmd("plan_burst", 1'b1, 1'b0, 16'h8000, 8'h00, 2);
    run_burst_data(w, 0);
    cyc(2);

    // Video and CPU read in the same idle cycle: video goes first.
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0102;
    bus.vid_req = 1'b1; bus.vid_addr = 16'hA000;
    cyc();
    bus.vid_req = 1'b0;
    chk("prio_video_first", bus.mem_burst, 1);
    serve_cmd("prio_burst", 1'b1, 1'b0, 16'hA000, 8'h00, 1);
    run_burst_data(w, 1);
    d0 = n_ack;
    serve_cmd("prio_cpu", 1'b0, 1'b0, 16'h0102, 8'h00, 1);
    send_word(32'hAABBCCDD, 0);
    chk("prio_cpu_ack", bus.cpu_ack, 1);
    chk("prio_cpu_dout", bus.cpu_dout, 8'hBB);
    bus.cpu_req = 1'b0;
    cyc(2);
    chk("prio_one_ack", n_ack, d0 + 1);

    // CPU write held through the ack cycle.
    cpu_access(1'b1, 16'h1234, 8'h5A, 32'h0, 0, 1'b1);

    // Two video requests during a CPU access: overrun, single burst at the newest address.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0203;
    wait_req("ovr_cpu");
    bus.vid_req = 1'b1; bus.vid_addr = 16'h8000;
    cyc();
    bus.vid_addr = 16'h8040;
    cyc();
    bus.vid_req = 1'b0;
    exp_overrun = 1'b1;
    chk("overrun_set", bus.vid_overrun, exp_overrun);
    chk("ovr_cpu_not_preempted", bus.mem_burst, 0);
    bus.mem_ack = 1'b1;
    cyc();
    bus.mem_ack = 1'b0;
    send_word(32'h12345678, 1);
    chk("ovr_cpu_ack", bus.cpu_ack, 1);
    chk("ovr_cpu_dout", bus.cpu_dout, 8'h12);
    bus.cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    serve_cmd("ovr_burst", 1'b1, 1'b0, 16'h8040, 8'h00, 1);
    run_burst_data(w, 1);
    cyc(5);
    chk("ovr_single_burst", bus.mem_req, 0);

    // Randomized mix against the reference expectations.
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 2))
        0: video_burst(16'($urandom), $urandom_range(0, 3), 2);
        1: cpu_access(1'b0, 16'($urandom), 8'h00, $urandom, $urandom_range(0, 3), 1'($urandom));
        default: cpu_access(1'b1, 16'($urandom), 8'($urandom), 32'h0, $urandom_range(0, 3), 1'($urandom));
      endcase
      cyc($urandom_range(0, 2));
    end
    chk("overrun_sticky", bus.vid_overrun, exp_overrun);

`ifdef VIDARB_WATCHDOG_EN
    d0 = n_done;
    bus.vid_req = 1'b1; bus.vid_addr = 16'h4000;
    cyc();
    bus.vid_req = 1'b0;
    cnt = 0;
    while (bus.mem_req === 1'b1 && cnt < 200) begin
      cyc();
      cnt++;
    end
    exp_err = 1'b1;
    chk("wd_cycles", cnt, 64);
    chk("wd_mem_err", bus.mem_err, exp_err);
    chk("wd_slice", bus.video_slice, 0);
    chk("wd_vdata", bus.vdata, exp_v[0]);
    chk("wd_vdata4", bus.vdata4, exp_v[3]);
    cyc(2);
    chk("wd_no_vid_done", n_done, d0);
    cpu_access(1'b1, 16'h0040, 8'hC3, 32'h0, 1, 1'b0);
`endif
    chk("mem_err_state", bus.mem_err, exp_err);

    // Reset in the middle of a burst.
    d0 = n_done;
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    bus.vid_req = 1'b1; bus.vid_addr = 16'h7777;
    cyc();
    bus.vid_req = 1'b0;
    serve_cmd("rst_burst", 1'b1, 1'b0, 16'h7777, 8'h00, 0);
    send_word(w[0], 0);
    send_word(w[1], 0);
    reset = 1'b1;
    cyc();
    check_idle_outputs("mid_reset");
    cyc();
    reset = 1'b0;
    cyc(5);
    chk("rst_no_vid_done", n_done, d0);
    chk("rst_idle", bus.mem_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
